prbs_sweep_ctrl: RTL
====================

PRBS_SWEEP_CTRL -- requirements
Module: prbs_sweep_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock (100 MHz), all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  sweep request, sampled only in IDLE.
REQ-004 SHALL have port: freq_start  input  32  first divider value of the sweep.
REQ-005 SHALL have port: freq_step  input  32  divider increment per step.
REQ-006 SHALL have port: num_steps  input  8  number of sweep steps; 0 means an empty sweep.
REQ-007 SHALL have port: dwell_cycles  input  16  generator rollovers per step; 0 is treated as 1.
REQ-008 SHALL have port: gen_signal_out  input  1  PRBS bit from the generator.
REQ-009 SHALL have port: gen_signal_cycle  input  1  generator rollover pulse.
REQ-010 SHALL have port: gen_reset  output  1  drives the generator reset.
REQ-011 SHALL have port: gen_user_freq  output  32  drives the generator divider value.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done  output  1  single-cycle end-of-sweep pulse.
REQ-014 SHALL have ports: res_valid output 1, res_ready input 1, res_step output 8, res_freq output 32, res_ones output 32; together they form the per-step result handshake.

Function
REQ-015 SHALL implement the FSM IDLE -> GEN_RST -> DWELL -> REPORT -> (GEN_RST | DONE) -> IDLE.
REQ-016 IDLE: on start=1, SHALL latch freq_start, freq_step, num_steps and dwell_cycles, then go to DONE if num_steps=0, else go to GEN_RST with step=0 and freq=freq_start.
REQ-017 SHALL ignore start in every state except IDLE; latched configuration SHALL NOT change mid-sweep.
REQ-018 GEN_RST: gen_reset=1 for exactly 2 clocks, then go to DWELL; gen_user_freq SHALL equal the current freq from GEN_RST entry onward.
REQ-019 DWELL: gen_reset=0; each clock with gen_signal_out=1 SHALL increment the ones counter, saturating at 0xFFFFFFFF.
REQ-020 DWELL: each gen_signal_cycle pulse SHALL increment the rollover counter; on the pulse that reaches the effective dwell count, SHALL go to REPORT, with that cycle's gen_signal_out sample included.
REQ-021 REPORT: res_valid=1, gen_reset=1; res_step, res_freq and res_ones SHALL stay stable until res_valid and res_ready are both 1.
REQ-022 On handshake: if step=num_steps-1, SHALL go to DONE; else step+1, freq=freq+freq_step (mod 2^32, wrap permitted), clear both counters, go to GEN_RST.
REQ-023 DONE: done=1 for one clock, gen_reset=1, then go to IDLE; res_valid SHALL be 0 outside REPORT.
REQ-024 gen_reset SHALL be 1 in IDLE, GEN_RST, REPORT and DONE.
REQ-025 res_ready=1 on REPORT entry SHALL complete the handshake in that same clock (1-cycle REPORT minimum).

Reset
REQ-026 On reset: state=IDLE, gen_reset=1, gen_user_freq=0, busy=0, done=0, res_valid=0, res_step=0, res_freq=0, res_ones=0, and all counters=0.
REQ-027 Reset asserted mid-sweep SHALL abort immediately, with no done pulse and no pending result retained.

Configuration
REQ-028 With SWEEP_ABORT_EN defined: SHALL add input abort (1 bit); abort=1 in any non-IDLE state SHALL go to DONE next clock (done pulse issued) and drop any pending result; abort in IDLE is ignored.
REQ-029 Without SWEEP_ABORT_EN: no abort port; a sweep ends only on completion or reset.

Verification
REQ-030 Sweep: freq_start=3000, freq_step=1000, num_steps=3, dwell_cycles=2, res_ready=1 -> 3 results with res_freq 3000/4000/5000, res_step 0/1/2, then one done pulse.
REQ-031 num_steps=0 -> done 2 clocks after start, no res_valid, gen_reset never low.
REQ-032 Backpressure: res_ready=0 for 50 clocks in REPORT -> res_* stable, gen_reset=1, no step advance until res_ready=1.
REQ-033 Wrap: freq_start=0xFFFFFC18, freq_step=1000, num_steps=2 -> res_freq 0xFFFFFC18 then 0x00000000.
REQ-034 Ones count: gen_signal_out forced 1, dwell_cycles=1, rollover 10 clocks into DWELL -> res_ones=10; dwell_cycles=0 behaves as 1.
REQ-035 Reset mid-DWELL -> all outputs at reset values next clock; with SWEEP_ABORT_EN, abort mid-DWELL -> done=1 next clock, then IDLE.

Source files
------------

// File: rtl/prbs_sweep_ctrl.sv
// Frequency sweep sequencer for a PRBS generator: per step it resets the generator, counts ones over N rollovers, reports the count.
// Optional SWEEP_ABORT_EN adds an abort input that ends a running sweep through DONE.
module prbs_sweep_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] freq_start,
  input  logic [31:0] freq_step,
  input  logic [7:0]  num_steps,
  input  logic [15:0] dwell_cycles,
  input  logic        gen_signal_out,
  input  logic        gen_signal_cycle,
`ifdef SWEEP_ABORT_EN
  input  logic        abort,
`endif
  output logic        gen_reset,
  output logic [31:0] gen_user_freq,
  output logic        busy,
  output logic        done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_step,
  output logic [31:0] res_freq,
  output logic [31:0] res_ones
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN_RST, S_DWELL, S_REPORT, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_freq_step;
  logic [7:0]  r_num_steps;
  logic [15:0] r_dwell;
  logic [7:0]  r_step;
  logic [31:0] r_freq;
  logic [31:0] r_ones;
  logic [15:0] r_roll;
  logic        r_rst_cnt;
  logic        r_gen_reset;
  logic        r_busy;
  logic        r_done;
  logic        r_res_valid;
  logic [7:0]  r_res_step;
  logic [31:0] r_res_freq;
  logic [31:0] r_res_ones;

  logic [31:0] w_ones_next;
  logic [15:0] w_roll_next;
  logic [15:0] w_dwell_eff;
  logic        w_dwell_hit;
  logic        w_last;
  logic        w_abort;

`ifdef SWEEP_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Ones count saturates rather than wrapping so a long dwell never under-reports.
  assign w_ones_next = (gen_signal_out && (r_ones != 32'hFFFF_FFFF)) ? r_ones + 32'd1 : r_ones;
  assign w_roll_next = r_roll + 16'd1;
  assign w_dwell_eff = (r_dwell == 16'd0) ? 16'd1 : r_dwell;
  assign w_dwell_hit = gen_signal_cycle && (w_roll_next == w_dwell_eff);
  assign w_last      = (r_step == r_num_steps - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_freq_step <= '0;
      r_num_steps <= '0;
      r_dwell     <= '0;
      r_step      <= '0;
      r_freq      <= '0;
      r_ones      <= '0;
      r_roll      <= '0;
      r_rst_cnt   <= 1'b0;
      r_gen_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_step  <= '0;
      r_res_freq  <= '0;
      r_res_ones  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
        r_state     <= S_DONE;
        r_done      <= 1'b1;
        r_res_valid <= 1'b0;
        r_gen_reset <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_freq_step <= freq_step;
              r_num_steps <= num_steps;
              r_dwell     <= dwell_cycles;
              r_step      <= '0;
              r_freq      <= freq_start;
              r_ones      <= '0;
              r_roll      <= '0;
              r_rst_cnt   <= 1'b0;
              r_busy      <= 1'b1;
              if (num_steps == 8'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GEN_RST;
              end
            end
          end
          S_GEN_RST: begin
            if (r_rst_cnt) begin
              r_state     <= S_DWELL;
              r_gen_reset <= 1'b0;
            end else begin
              r_rst_cnt <= 1'b1;
            end
          end
          S_DWELL: begin
            r_ones <= w_ones_next;
            if (gen_signal_cycle) r_roll <= w_roll_next;
            // The rollover cycle's own bit is part of the reported count.
            if (w_dwell_hit) begin
              r_state     <= S_REPORT;
              r_gen_reset <= 1'b1;
              r_res_valid <= 1'b1;
              r_res_step  <= r_step;
              r_res_freq  <= r_freq;
              r_res_ones  <= w_ones_next;
            end
          end
          S_REPORT: begin
            if (res_ready) begin
              r_res_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_GEN_RST;
                r_step    <= r_step + 8'd1;
                r_freq    <= r_freq + r_freq_step;
                r_ones    <= '0;
                r_roll    <= '0;
                r_rst_cnt <= 1'b0;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign gen_reset     = r_gen_reset;
  assign gen_user_freq = r_freq;
  assign busy          = r_busy;
  assign done          = r_done;
  assign res_valid     = r_res_valid;
  assign res_step      = r_res_step;
  assign res_freq      = r_res_freq;
  assign res_ones      = r_res_ones;

endmodule
